// File: rtl/cpu_trace_pkg.sv
// Shared constants for the CPU trace buffer: capture modes and the packed entry layout.
// Entry layout, MSB to LSB: {pc, opcode, acc, mr, flags}.
package cpu_trace_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_TRACE = 2'd2;
    localparam logic [1:0] MODE_RING  = 2'd3;

    localparam int FLAGS_LSB = 0;

    function automatic int entry_w(input int pc_w, input int op_w,
                                   input int data_w, input int flag_w);
        return pc_w + op_w + 2 * data_w + flag_w;
    endfunction

    function automatic int mr_lsb(input int flag_w);
        return flag_w;
    endfunction

    function automatic int acc_lsb(input int flag_w, input int data_w);
        return flag_w + data_w;
    endfunction

    function automatic int op_lsb(input int flag_w, input int data_w);
        return flag_w + 2 * data_w;
    endfunction

    function automatic int pc_lsb(input int flag_w, input int data_w, input int op_w);
        return flag_w + 2 * data_w + op_w;
    endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// Entry storage for the trace buffer: one write and one registered read per cycle.
// The array itself is not reset; only the read register and its valid flag are.
module trace_ring_mem #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 45,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_dat,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [ENTRY_W-1:0] o_rd_dat,
    output logic               o_rd_vld
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_dat;
    logic               r_rd_vld;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Read samples the array before this edge's write lands, so a same-address
    // write and read returns the old entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= i_rd_en;
            if (i_rd_en) begin
                r_rd_dat <= r_mem[i_rd_addr];
            end
        end
    end

    assign o_rd_dat = r_rd_dat;
    assign o_rd_vld = r_rd_vld;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures {pc, opcode, acc, mr, flags} snapshots in step, trace or ring mode and
// drains them through a one-cycle-latency pop port; ring mode freezes on halt.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int OP_W   = 8,
    parameter int DATA_W = 16,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start_cpu,
    input  logic [1:0]               i_mode,
    input  logic                     i_user_sample,
    input  logic                     i_instr_commit,
    input  logic                     i_halt,
    input  logic [PC_W-1:0]          i_pc,
    input  logic [OP_W-1:0]          i_opcode,
    input  logic [DATA_W-1:0]        i_acc,
    input  logic [DATA_W-1:0]        i_mr,
    input  logic [FLAG_W-1:0]        i_flags,
    input  logic                     i_clear,
    input  logic                     i_rd_req,
    output logic                     o_rd_valid,
    output logic [PC_W-1:0]          o_rd_pc,
    output logic [OP_W-1:0]          o_rd_opcode,
    output logic [DATA_W-1:0]        o_rd_acc,
    output logic [DATA_W-1:0]        o_rd_mr,
    output logic [FLAG_W-1:0]        o_rd_flags,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_frozen
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = entry_w(PC_W, OP_W, DATA_W, FLAG_W);
    localparam int MR_LSB  = mr_lsb(FLAG_W);
    localparam int ACC_LSB = acc_lsb(FLAG_W, DATA_W);
    localparam int OP_LSB  = op_lsb(FLAG_W, DATA_W);
    localparam int PC_LSB  = pc_lsb(FLAG_W, DATA_W, OP_W);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic               r_frozen;
    logic               r_sample_d;
    logic               r_halt_d;

    logic               w_sample_rise;
    logic               w_halt_rise;
    logic               w_ring;
    logic               w_cap;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_overwrite;
    logic               w_drop;
    logic               w_wr_en;
    logic               w_rd_adv;
    logic [ENTRY_W-1:0] w_wr_dat;
    logic [ENTRY_W-1:0] w_rd_dat;

    assign w_sample_rise = i_user_sample & ~r_sample_d;
    assign w_halt_rise   = i_halt & ~r_halt_d;
    assign w_ring        = (i_mode == MODE_RING);
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CW'(DEPTH));

    assign w_cap = i_start_cpu & ~r_frozen &
                   (((i_mode == MODE_STEP) & w_sample_rise) |
                    (((i_mode == MODE_TRACE) | w_ring) & i_instr_commit));

    assign w_pop = i_rd_req & ~w_empty & ~i_clear;

    // A pop in the same cycle frees a slot, so full only bites when nothing is popped.
    assign w_overwrite = w_cap & w_full & w_ring & ~w_pop;
    assign w_drop      = w_cap & w_full & ~w_ring & ~w_pop;
    assign w_wr_en     = w_cap & ~w_drop & ~i_clear;
    assign w_rd_adv    = w_pop | w_overwrite;

    assign w_wr_dat = {i_pc, i_opcode, i_acc, i_mr, i_flags};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample_d <= 1'b0;
            r_halt_d   <= 1'b0;
        end else begin
            r_sample_d <= i_user_sample;
            r_halt_d   <= i_halt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_frozen   <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_frozen   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_en & ~w_pop & ~w_overwrite) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop & ~w_wr_en) begin
                r_count <= r_count - CW'(1);
            end
            if (w_overwrite | w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_halt_rise & w_ring) begin
                r_frozen <= 1'b1;
            end
        end
    end

    trace_ring_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .AW      (AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (w_wr_dat),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_dat),
        .o_rd_vld  (o_rd_valid)
    );

    assign o_rd_pc     = w_rd_dat[PC_LSB  +: PC_W];
    assign o_rd_opcode = w_rd_dat[OP_LSB  +: OP_W];
    assign o_rd_acc    = w_rd_dat[ACC_LSB +: DATA_W];
    assign o_rd_mr     = w_rd_dat[MR_LSB  +: DATA_W];
    assign o_rd_flags  = w_rd_dat[FLAGS_LSB +: FLAG_W];

    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;
    assign o_frozen   = r_frozen;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer at DEPTH=4: step, trace and ring modes,
// simultaneous cap/pop, clear priority, disabled capture and async reset.
module tb_cpu_trace_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start_cpu;
    logic [1:0]  i_mode;
    logic        i_user_sample;
    logic        i_instr_commit;
    logic        i_halt;
    logic [7:0]  i_pc;
    logic [7:0]  i_opcode;
    logic [15:0] i_acc;
    logic [15:0] i_mr;
    logic [4:0]  i_flags;
    logic        i_clear;
    logic        i_rd_req;
    logic        o_rd_valid;
    logic [7:0]  o_rd_pc;
    logic [7:0]  o_rd_opcode;
    logic [15:0] o_rd_acc;
    logic [15:0] o_rd_mr;
    logic [4:0]  o_rd_flags;
    logic [2:0]  o_count;
    logic        o_empty;
    logic        o_full;
    logic        o_overflow;
    logic        o_frozen;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    cpu_trace_buffer #(
        .PC_W(8), .OP_W(8), .DATA_W(16), .FLAG_W(5), .DEPTH(4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start_cpu    (i_start_cpu),
        .i_mode         (i_mode),
        .i_user_sample  (i_user_sample),
        .i_instr_commit (i_instr_commit),
        .i_halt         (i_halt),
        .i_pc           (i_pc),
        .i_opcode       (i_opcode),
        .i_acc          (i_acc),
        .i_mr           (i_mr),
        .i_flags        (i_flags),
        .i_clear        (i_clear),
        .i_rd_req       (i_rd_req),
        .o_rd_valid     (o_rd_valid),
        .o_rd_pc        (o_rd_pc),
        .o_rd_opcode    (o_rd_opcode),
        .o_rd_acc       (o_rd_acc),
        .o_rd_mr        (o_rd_mr),
        .o_rd_flags     (o_rd_flags),
        .o_count        (o_count),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_overflow     (o_overflow),
        .o_frozen       (o_frozen)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] pc);
        i_rd_req = 1'b1;
        step();
        i_rd_req = 1'b0;
        chk({tag, "_vld"}, 32'(o_rd_valid), 32'd1);
        chk({tag, "_pc"}, 32'(o_rd_pc), 32'(pc));
    endtask

    task automatic commit(input logic [7:0] pc);
        i_pc = pc;
        i_instr_commit = 1'b1;
        step();
        i_instr_commit = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_start_cpu = 1'b0; i_mode = 2'd0; i_user_sample = 1'b0;
        i_instr_commit = 1'b0; i_halt = 1'b0; i_pc = 8'h00; i_opcode = 8'hA5;
        i_acc = 16'h1234; i_mr = 16'hBEEF; i_flags = 5'h15; i_clear = 1'b0; i_rd_req = 1'b0;
        step(); step();
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_frozen", 32'(o_frozen), 32'd0);
        chk("rst_vld", 32'(o_rd_valid), 32'd0);
        chk("rst_pc", 32'(o_rd_pc), 32'd0);
        i_rst_n = 1'b1;
        step();

        // Mode 1: three sample edges, then three back-to-back pops
        i_start_cpu = 1'b1; i_mode = 2'd1;
        for (int k = 0; k < 3; k++) begin
            i_pc = 8'h10 + 8'(k); i_user_sample = 1'b1; step();
            i_pc = 8'hFF; i_user_sample = 1'b0; step();
        end
        chk("m1_count", 32'(o_count), 32'd3);
        i_rd_req = 1'b1;
        step();
        chk("m1_pop0_vld", 32'(o_rd_valid), 32'd1);
        chk("m1_pop0_pc", 32'(o_rd_pc), 32'h10);
        chk("m1_pop0_op", 32'(o_rd_opcode), 32'hA5);
        chk("m1_pop0_acc", 32'(o_rd_acc), 32'h1234);
        chk("m1_pop0_mr", 32'(o_rd_mr), 32'hBEEF);
        chk("m1_pop0_flags", 32'(o_rd_flags), 32'h15);
        step();
        chk("m1_pop1_vld", 32'(o_rd_valid), 32'd1);
        chk("m1_pop1_pc", 32'(o_rd_pc), 32'h11);
        step();
        chk("m1_pop2_vld", 32'(o_rd_valid), 32'd1);
        chk("m1_pop2_pc", 32'(o_rd_pc), 32'h12);
        i_rd_req = 1'b0;
        step();
        chk("m1_idle_vld", 32'(o_rd_valid), 32'd0);
        chk("m1_hold_pc", 32'(o_rd_pc), 32'h12);
        chk("m1_empty", 32'(o_empty), 32'd1);

        // Level-held sample captures once
        i_pc = 8'h20; i_user_sample = 1'b1;
        repeat (5) step();
        i_user_sample = 1'b0;
        step();
        chk("m1_level_count", 32'(o_count), 32'd1);
        pop_expect("m1_level_pop", 8'h20);

        // Mode 2: six commits into four slots
        i_mode = 2'd2;
        for (int k = 0; k < 6; k++) commit(8'h30 + 8'(k));
        chk("m2_count", 32'(o_count), 32'd4);
        chk("m2_full", 32'(o_full), 32'd1);
        chk("m2_ovf", 32'(o_overflow), 32'd1);
        for (int k = 0; k < 4; k++) pop_expect("m2_pop", 8'h30 + 8'(k));
        chk("m2_empty", 32'(o_empty), 32'd1);
        chk("m2_ovf_sticky", 32'(o_overflow), 32'd1);

        // Clear beats simultaneous cap and pop at count 3
        for (int k = 0; k < 3; k++) commit(8'h38 + 8'(k));
        chk("clr_pre_count", 32'(o_count), 32'd3);
        i_clear = 1'b1; i_instr_commit = 1'b1; i_rd_req = 1'b1; i_pc = 8'h3F;
        step();
        i_clear = 1'b0; i_instr_commit = 1'b0; i_rd_req = 1'b0;
        chk("clr_count", 32'(o_count), 32'd0);
        chk("clr_empty", 32'(o_empty), 32'd1);
        chk("clr_vld", 32'(o_rd_valid), 32'd0);
        chk("clr_ovf", 32'(o_overflow), 32'd0);

        // Full FIFO: simultaneous commit and pop
        for (int k = 0; k < 4; k++) commit(8'h40 + 8'(k));
        chk("ff_pre_full", 32'(o_full), 32'd1);
        i_pc = 8'h44; i_instr_commit = 1'b1; i_rd_req = 1'b1;
        step();
        i_instr_commit = 1'b0; i_rd_req = 1'b0;
        chk("ff_vld", 32'(o_rd_valid), 32'd1);
        chk("ff_pc", 32'(o_rd_pc), 32'h40);
        chk("ff_count", 32'(o_count), 32'd4);
        chk("ff_ovf", 32'(o_overflow), 32'd0);
        for (int k = 1; k < 5; k++) pop_expect("ff_drain", 8'h40 + 8'(k));

        // Mode 3: ten commits, halt freezes, later commits ignored
        i_mode = 2'd3;
        for (int k = 0; k < 10; k++) commit(8'(k));
        chk("m3_count", 32'(o_count), 32'd4);
        chk("m3_ovf", 32'(o_overflow), 32'd1);
        i_halt = 1'b1;
        step();
        chk("m3_frozen", 32'(o_frozen), 32'd1);
        commit(8'h50);
        commit(8'h51);
        chk("m3_frozen_count", 32'(o_count), 32'd4);
        for (int k = 6; k < 10; k++) pop_expect("m3_pop", 8'(k));
        chk("m3_empty", 32'(o_empty), 32'd1);
        chk("m3_still_frozen", 32'(o_frozen), 32'd1);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0; i_halt = 1'b0;
        chk("m3_clr_frozen", 32'(o_frozen), 32'd0);

        // Mode 3 full ring with simultaneous commit and pop
        for (int k = 0; k < 4; k++) commit(8'(k));
        i_pc = 8'h04; i_instr_commit = 1'b1; i_rd_req = 1'b1;
        step();
        i_instr_commit = 1'b0; i_rd_req = 1'b0;
        chk("rs_pc", 32'(o_rd_pc), 32'h00);
        chk("rs_count", 32'(o_count), 32'd4);
        chk("rs_ovf", 32'(o_overflow), 32'd0);
        for (int k = 1; k < 5; k++) pop_expect("rs_drain", 8'(k));

        // Capture disabled: CPU stopped, then mode off
        i_start_cpu = 1'b0; i_mode = 2'd2;
        for (int k = 0; k < 6; k++) begin
            i_instr_commit = k[0]; i_user_sample = k[0]; step();
        end
        chk("stop_count", 32'(o_count), 32'd0);
        i_start_cpu = 1'b1; i_mode = 2'd0;
        for (int k = 0; k < 6; k++) begin
            i_instr_commit = k[0]; i_user_sample = k[0]; step();
        end
        i_instr_commit = 1'b0; i_user_sample = 1'b0;
        chk("off_count", 32'(o_count), 32'd0);
        i_rd_req = 1'b1;
        step();
        i_rd_req = 1'b0;
        chk("empty_pop_vld", 32'(o_rd_valid), 32'd0);

        // Asynchronous reset mid-cycle
        i_mode = 2'd2;
        commit(8'h60);
        commit(8'h61);
        pop_expect("ar_pop", 8'h60);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_vld", 32'(o_rd_valid), 32'd0);
        chk("ar_pc", 32'(o_rd_pc), 32'd0);
        chk("ar_empty", 32'(o_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised capture and trace buffer for CPU architectural state. It is the next-generation replacement for the single-entry user sample registers at CPU top level. It records {PC, opcode, ACC, MR, flags} snapshots into a DEPTH-entry buffer in one of three capture modes. The user interface drains the buffer through a registered read port. It sits beside the CPU core at top level, fed by the register file user taps and the control unit.

## Interface
- PC_W, 8, program counter width
- OP_W, 8, opcode width
- DATA_W, 16, ACC and MR width
- FLAG_W, 5, ALU flag width
- DEPTH, 16, number of entries; power of two, ≥2
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_start_cpu  in  1  CPU running; captures are ignored while low
- i_mode  in  2  0=off, 1=step sample, 2=instruction trace, 3=ring-until-halt
- i_user_sample  in  1  user sample request, level; rising edge is the event in mode 1
- i_instr_commit  in  1  one-cycle pulse at instruction completion; event in modes 2 and 3
- i_halt  in  1  CPU halt, level; rising edge freezes the buffer in mode 3
- i_pc, i_opcode, i_acc, i_mr, i_flags  in  PC_W/OP_W/DATA_W/DATA_W/FLAG_W  live state to capture
- i_clear  in  1  synchronous clear
- i_rd_req  in  1  pop request
- o_rd_valid  out  1  read data valid pulse
- o_rd_pc, o_rd_opcode, o_rd_acc, o_rd_mr, o_rd_flags  out  widths as inputs  popped entry
- o_count  out  $clog2(DEPTH)+1  entries held
- o_empty, o_full  out  1  count==0 / count==DEPTH
- o_overflow  out  1  sticky: an entry was dropped or overwritten
- o_frozen  out  1  mode 3 halt freeze active

## Operation
- Capture event cap:
  - cap = i_start_cpu & !o_frozen & (mode1 & user_sample rising edge | mode2/3 & i_instr_commit).
  - Edge detection uses internal registers of i_user_sample and i_halt; these reset to 0.
- The entry is taken from the live inputs in the cycle of cap.
- Modes 1 and 2 (FIFO): cap while full drops the new entry and sets o_overflow.
- Mode 3 (ring): cap while full overwrites the oldest entry, advances the read pointer, and sets o_overflow. A rising edge of i_halt sets o_frozen, and capture stops.
- Pop: i_rd_req & !o_empty returns the oldest entry. i_rd_req while empty is ignored and produces no o_rd_valid.
- Simultaneous cap and pop:
  - count is unchanged.
  - If full in mode 3, the read pointer advances once only. The pop returns the entry at the pre-cycle read pointer, and o_overflow is not set.
  - If full in modes 1/2, the write succeeds because a slot is freed in the same cycle; no overflow.
- i_clear takes priority over cap and pop. It zeroes the pointers, count, o_overflow and o_frozen. o_rd_valid is 0 that cycle. Array contents are don't-care.
- A mode change keeps the stored contents. o_frozen clears only on i_clear or reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.

## Timing
- Reset values:
  - o_count=0, o_empty=1, o_full=0, o_overflow=0, o_frozen=0.
  - o_rd_valid=0 and all o_rd_* = 0.
  - Edge registers = 0.
- Capture: the entry is written at the edge ending the cap cycle. o_count, o_full and o_overflow update at that same edge, visible the next cycle.
- Read latency is 1: pop at cycle n gives o_rd_valid=1 and o_rd_* in cycle n+1. o_rd_* hold their value until the next pop.
- Back-to-back pops are sustained at one per cycle.
- Halt edge at cycle n: o_frozen=1 from n+1. An i_instr_commit in cycle n is still captured.
- Asynchronous reset mid-operation returns all state to reset values immediately.

## Structure
- Package cpu_trace_pkg holds:
  - mode constants MODE_OFF, MODE_STEP, MODE_TRACE, MODE_RING;
  - the function computing entry width ENTRY_W = PC_W+OP_W+2*DATA_W+FLAG_W;
  - the field offset constants.
- Sub-module trace_ring_mem holds the DEPTH×ENTRY_W array and the registered read port: 1 write and 1 read per cycle, no reset on the array.
- The top owns the pointers, count, edge detection, mode and freeze logic.

## Test plan
- Mode 1, DEPTH=4, i_start_cpu=1: three user_sample rising edges with PC=0x10/0x11/0x12, then 3 pops. Expect o_rd_pc 0x10, 0x11, 0x12 each one cycle after its pop; o_empty=1 afterwards. Holding i_user_sample high for 5 cycles captures only 1 entry.
- Mode 2: 6 commits into DEPTH=4. Expect o_count=4, o_full=1, o_overflow=1; pops return the first 4 PCs.
- Mode 3: commits with PC 0..9 into DEPTH=4, then an i_halt rising edge, then 2 more commits. Expect o_frozen=1, o_count=4, pops return PC 6,7,8,9, o_overflow=1.
- Full FIFO with simultaneous commit and pop: count stays 4, o_overflow stays 0, and the popped entry is the oldest.
- i_clear asserted in the same cycle as cap and pop with count=3: next cycle o_count=0, o_empty=1, o_rd_valid=0, o_overflow=0.
- i_start_cpu=0 or mode 0 with commits and samples toggling: o_count remains 0. A pop on empty produces no o_rd_valid.
